// File: rtl/fsm.sv
// Serial detector for the 8-bit HDLC flag 01111110 (first bit 0).
// Moore machine: y pulses for one cycle on the edge that samples the closing 0.
module fsm (
  input  logic clk,
  input  logic reset,
  input  logic w,
  output logic y
);

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7,
    S8 = 4'd8
  } state_t;

  state_t state;

  // y is registered alongside the state and equals (state == S8) at all times.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
      y     <= 1'b0;
    end else begin
      y <= 1'b0;
      case (state)
        S0: state <= w ? S0 : S1;
        S1: state <= w ? S2 : S1;
        S2: state <= w ? S3 : S1;
        S3: state <= w ? S4 : S1;
        S4: state <= w ? S5 : S1;
        S5: state <= w ? S6 : S1;
        S6: state <= w ? S7 : S1;
        S7: begin
          // a seventh consecutive 1 leaves no suffix worth keeping
          if (w) begin
            state <= S0;
          end else begin
            state <= S8;
            y     <= 1'b1;
          end
        end
        // the flag's closing 0 doubles as the next flag's opening 0
        S8: state <= w ? S2 : S1;
        default: state <= S0;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm.sv
// Directed-vector bench for the 01111110 flag detector.
module tb_fsm;

  logic clk;
  logic reset;
  logic w;
  logic y;

  int unsigned vectors;
  int unsigned miscompares;

  fsm dut (
    .clk   (clk),
    .reset (reset),
    .w     (w),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: y=%b expected %b", tag, got, exp);
    end
  endtask

  // Apply n bits (bits[n-1] first); y is checked 1 time unit after each edge.
  task automatic run_seq(input string name, input logic [31:0] bits,
                         input logic [31:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      w = bits[n-1-i];
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", name, i), y, exp[n-1-i]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    w     = 1'b0;
    @(posedge clk);
    #1;
    check("reset", y, 1'b0);
    reset = 1'b0;

    run_seq("zeros",    32'b00000000,         32'b00000000,         8);
    run_seq("flag",     32'b01111110,         32'b00000001,         8);
    run_seq("seven1s",  32'b0111111110110110, 32'b0000000000000000, 16);
    run_seq("overlap7", 32'b011111101111110,  32'b000000010000001,  15);
    run_seq("overlap8", 32'b0111111001111110, 32'b0000000100000001, 16);
    run_seq("nearmiss", 32'b01111101111110,   32'b00000000000001,   14);

    // reset lands on the edge that samples the 7th bit of a flag
    run_seq("prerst",   32'b011111,           32'b000000,           6);
    w     = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset", y, 1'b0);
    reset = 1'b0;
    run_seq("postrst",  32'b0,                32'b0,                1);
    run_seq("flag2",    32'b01111110,         32'b00000001,         8);
    run_seq("tail",     32'b10,               32'b00,               2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
